rtc_timekeeper: RTL
===================

Name: rtc_timekeeper

Overview:
- Parametrised successor to the board's single-instance HH:MM:SS counter.
- Derives a tick from the system clock with a generic divider and keeps 24-hour binary time.
- Accepts manual button stepping and atomic range-checked loads (fed by the UART command decoder).
- Adds an HH:MM alarm, a day-wrap strobe and a 12/24-hour display view for the 7-seg driver.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
TICK_HZ, 1, tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer division, must be >= 2; counter width $clog2(DIV).
RST_SEC, 0, reset value of sec (0-59).
RST_MIN, 0, reset value of min (0-59).
RST_HOUR, 0, reset value of hour (0-23).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
set  in  1  level; 1 = set mode, timekeeping frozen.
inc_sec  in  1  button level; rising edge steps seconds (set mode only).
inc_min  in  1  button level; rising edge steps minutes (set mode only).
inc_hour  in  1  button level; rising edge steps hours (set mode only).
load_valid  in  1  one-cycle strobe; load time from load_* fields.
load_sec  in  6  seconds to load.
load_min  in  6  minutes to load.
load_hour  in  5  hours to load.
load_ok  out  1  one-cycle pulse: load accepted.
load_err  out  1  one-cycle pulse: load rejected.
alarm_wr  in  1  strobe; capture alarm_min/alarm_hour_in (same range check, same ok/err pulses).
alarm_min  in  6  alarm minute.
alarm_hour_in  in  5  alarm hour.
alarm_en  in  1  enables alarm_hit.
mode12  in  1  1 = 12-hour display view.
sec  out  6  current seconds.
min  out  6  current minutes.
hour  out  5  current hours, 0-23.
hour_disp  out  5  display hour.
pm  out  1  PM indicator.
tick  out  1  one-cycle pulse per prescaler terminal count.
day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 advance.
alarm_hit  out  1  one-cycle pulse on an alarm match.

Behaviour:
- Reset (async, active low):
  - sec/min/hour = RST_* values; prescaler = 0.
  - Alarm registers = 0. All pulse outputs = 0. Edge-detect registers = 0.
- Prescaler:
  - Counts 0..DIV-1 while set = 0; tick = 1 for the one cycle the count equals DIV-1, then the count returns to 0.
  - While set = 1, prescaler is held at 0 and tick = 0.
- Tick advance (set = 0, registered, visible the cycle after tick):
  - sec+1; sec 59 -> 0 with min+1.
  - min 59 -> 0 with hour+1.
  - hour 23 -> 0 with day_wrap pulse.
- alarm_hit:
  - Pulses in the same cycle the advanced time becomes visible, when alarm_en = 1 and the new time is alarm_hour:alarm_min:00.
  - Never fires on loads or manual steps.
- Manual step (set = 1):
  - Each inc_* input is edge-detected; each 0->1 transition steps exactly one field by +1.
  - Each field wraps independently (sec 59->0, min 59->0, hour 23->0), with no carry and no day_wrap.
  - More than one rising edge in the same cycle: no change.
- Load:
  - load_valid is accepted in either mode.
  - Accepted iff load_sec <= 59, load_min <= 59 and load_hour <= 23: all three fields update atomically next cycle, load_ok pulses, and the prescaler is cleared to 0.
  - Otherwise time is unchanged and load_err pulses.
- Priority within one cycle: load > manual step > tick advance.
  - A load coinciding with a tick overrides the advance and suppresses alarm_hit/day_wrap for that tick.
- alarm_wr:
  - Independent of set and load.
  - If both alarm_wr and load_valid are strobed in the same cycle, load_ok/load_err report the time load and the alarm result is dropped (alarm still captured if valid).
- Display view (combinational from hour):
  - mode12 = 0: hour_disp = hour, pm = 0.
  - mode12 = 1: hour 0 -> 12, 1-11 -> same, 12 -> 12, 13-23 -> hour-12; pm = (hour >= 12).
- Outputs sec/min/hour are registered and never leave their ranges.
- Reset asserted mid-operation returns everything to reset values immediately; a pending load or edge is discarded.

Test Plan:
- CLK_HZ=10, TICK_HZ=1, RST=23:59:58; release reset, run 20 cycles -> tick at cycles 9 and 19; time 23:59:59 then 00:00:00; day_wrap one cycle with the 00:00:00 update.
- Load 12:34:56 -> load_ok, time 12:34:56 next cycle, prescaler 0; load hour=24 -> load_err, time unchanged.
- set=1, three inc_sec edges from sec=58 -> sec 59,0,1, min unchanged; inc_sec+inc_min rising together -> no change; tick stays 0 throughout.
- alarm_wr 07:00, alarm_en=1, load 06:59:59, run one tick -> time 07:00:00 and alarm_hit pulse; alarm_en=0 repeat -> no pulse; load 07:00:00 directly -> no pulse.
- mode12=1 sweep hour 0,1,11,12,13,23 -> hour_disp 12,1,11,12,1,11 and pm 0,0,0,1,1,1.
- Assert reset during a load_valid cycle -> time = RST values, load_ok stays 0.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24-hour binary clock with prescaled tick, manual
// stepping, range-checked loads, HH:MM alarm and a 12-hour display view.
module rtc_timekeeper #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int RST_SEC  = 0,
    parameter int RST_MIN  = 0,
    parameter int RST_HOUR = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       load_valid,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hour,
    output logic       load_ok,
    output logic       load_err,
    input  logic       alarm_wr,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hour_in,
    input  logic       alarm_en,
    input  logic       mode12,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic       tick,
    output logic       day_wrap,
    output logic       alarm_hit
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] pcnt, pcnt_n;
    logic [2:0]    inc_q, rise;
    logic [5:0]    al_min;
    logic [4:0]    al_hour;
    logic [5:0]    sec_n, min_n, adv_sec, adv_min;
    logic [4:0]    hour_n, adv_hour;
    logic          sec_end, min_end, hour_end;
    logic          load_rng, alarm_rng, step_one;
    logic          ok_n, err_n, dw_n, hit_n;

    assign tick      = !set && (pcnt == TERM);
    assign rise      = {inc_hour, inc_min, inc_sec} & ~inc_q;
    assign step_one  = $onehot(rise);
    assign sec_end   = (sec == 6'd59);
    assign min_end   = (min == 6'd59);
    assign hour_end  = (hour == 5'd23);
    assign load_rng  = (load_sec <= 6'd59) && (load_min <= 6'd59)
                    && (load_hour <= 5'd23);
    assign alarm_rng = (alarm_min <= 6'd59) && (alarm_hour_in <= 5'd23);

    // Carry chain for a normal one-second advance
    always_comb begin
        adv_sec  = sec_end ? 6'd0 : sec + 6'd1;
        adv_min  = min;
        adv_hour = hour;
        if (sec_end) begin
            adv_min = min_end ? 6'd0 : min + 6'd1;
            if (min_end)
                adv_hour = hour_end ? 5'd0 : hour + 5'd1;
        end
    end

    always_comb begin
        sec_n  = sec;
        min_n  = min;
        hour_n = hour;
        pcnt_n = (set || tick) ? '0 : pcnt + ONE;
        ok_n   = 1'b0;
        err_n  = 1'b0;
        dw_n   = 1'b0;
        hit_n  = 1'b0;
        if (load_valid) begin
            if (load_rng) begin
                sec_n  = load_sec;
                min_n  = load_min;
                hour_n = load_hour;
                pcnt_n = '0;
                ok_n   = 1'b1;
            end else begin
                err_n  = 1'b1;
            end
        end else if (set) begin
            if (step_one) begin
                unique case (1'b1)
                    rise[0]: sec_n  = sec_end  ? 6'd0 : sec + 6'd1;
                    rise[1]: min_n  = min_end  ? 6'd0 : min + 6'd1;
                    rise[2]: hour_n = hour_end ? 5'd0 : hour + 5'd1;
                    default: ;
                endcase
            end
        end else if (tick) begin
            sec_n  = adv_sec;
            min_n  = adv_min;
            hour_n = adv_hour;
            dw_n   = sec_end && min_end && hour_end;
            hit_n  = alarm_en && (adv_sec == 6'd0)
                  && (adv_min == al_min) && (adv_hour == al_hour);
        end
        // A coincident time load owns the ok/err pulses
        if (alarm_wr && !load_valid) begin
            ok_n  = alarm_rng;
            err_n = !alarm_rng;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec       <= 6'(RST_SEC);
            min       <= 6'(RST_MIN);
            hour      <= 5'(RST_HOUR);
            pcnt      <= '0;
            inc_q     <= '0;
            al_min    <= '0;
            al_hour   <= '0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            sec       <= sec_n;
            min       <= min_n;
            hour      <= hour_n;
            pcnt      <= pcnt_n;
            inc_q     <= {inc_hour, inc_min, inc_sec};
            load_ok   <= ok_n;
            load_err  <= err_n;
            day_wrap  <= dw_n;
            alarm_hit <= hit_n;
            if (alarm_wr && alarm_rng) begin
                al_min  <= alarm_min;
                al_hour <= alarm_hour_in;
            end
        end
    end

    always_comb begin
        hour_disp = hour;
        pm        = 1'b0;
        if (mode12) begin
            pm = (hour >= 5'd12);
            if (hour == 5'd0)
                hour_disp = 5'd12;
            else if (hour > 5'd12)
                hour_disp = hour - 5'd12;
        end
    end
endmodule
